regfile_read_port: RTL
======================

Name: regfile_read_port

Overview:
- 16-bit register file with one write port and two registered read ports.
- Sits in the decode stage.
- Write side is driven by the writeback stage, using the same `en_write` style as the single `Register` cells.
- Read side presents operands A/B to execute one cycle after address presentation.
- Supports stall (hold), flush, same-cycle write bypass, and write-while-held refresh.

Parameters:
- WIDTH, 16, data width of every register and read/write data port.
- ADDR_W, 4, register address width (16 slots).
- NUM_REGS, 12, implemented slots 0..NUM_REGS-1 (R0-R7, SP=8, IH=9, T=10, RA=11); slots at or above NUM_REGS are unimplemented.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- en_write  input  1  write strobe from writeback
- waddr  input  ADDR_W  write address
- wdata  input  WIDTH  write data
- re  input  1  read enable; 0 = stall, hold outputs
- flush  input  1  invalidate the read outputs
- raddr_a  input  ADDR_W  operand A address
- raddr_b  input  ADDR_W  operand B address
- rdata_a  output  WIDTH  operand A, registered
- rdata_b  output  WIDTH  operand B, registered
- rvalid  output  1  rdata_a/rdata_b hold a valid read

Behaviour:
- Reset (reset=1 at a rising edge):
  - all NUM_REGS storage slots <= 0;
  - rdata_a, rdata_b <= 0; rvalid <= 0;
  - internal held addresses <= 0.
  - Reset overrides every other input, including en_write in the same cycle.
- Write:
  - en_write=1 and waddr<NUM_REGS: slot[waddr] <= wdata at the edge.
  - waddr>=NUM_REGS: the write is dropped and no state changes.
  - Writes are independent of re and flush.
- Read (reset=0, flush=0, re=1):
  - at the edge, capture raddr_a/raddr_b into the held addresses;
  - rdata_x <= bypass ? wdata : slot[raddr_x];
  - bypass = en_write && waddr==raddr_x && waddr<NUM_REGS;
  - raddr_x>=NUM_REGS reads 0;
  - rvalid <= 1.
  - Latency: 1 cycle from address to rdata. Throughput: 1 read per cycle.
- Stall (reset=0, flush=0, re=0):
  - held addresses and rvalid are unchanged.
  - rdata_x keeps its value, except when en_write=1 and waddr==held_addr_x (implemented slot). Then rdata_x <= wdata, so held operands never go stale.
- Flush (reset=0, flush=1):
  - rdata_a, rdata_b <= 0; rvalid <= 0; held addresses <= 0.
  - Flush takes priority over re.
  - A write in the same cycle still updates storage.
- Priority: reset > flush > re/stall. Bypass and refresh are evaluated independently for A and B.
- Both ports may address the same slot. Each port returns an identical value.
- No combinational path from any input to any output. All outputs are flops.
- Reset mid-operation (e.g. during a stall) discards held state. The first read after reset returns 0 for every slot.

Test Plan:
1. Reset, then read A=3, B=11 with re=1 → next cycle rdata_a=0x0000, rdata_b=0x0000, rvalid=1.
2. Write slot 5=0xBEEF; next cycle read A=5, B=5 → rdata_a=rdata_b=0xBEEF.
3. Same-cycle bypass: en_write=1, waddr=2, wdata=0x1234 with raddr_a=2, re=1 → next cycle rdata_a=0x1234. Slot 2 also reads 0x1234 afterwards.
4. Stall refresh: read A=7 (slot holds 0x0001), then re=0 for 3 cycles while writing slot 7=0x00FF in stall cycle 2:
   - rdata_a=0x0001 through the edge of stall cycle 2, then 0x00FF;
   - rvalid stays 1.
5. Unimplemented slots: write waddr=13, wdata=0xAAAA; read A=13 → rdata_a=0x0000; no implemented slot changed.
6. Flush vs re: flush=1, re=1, en_write=1 (slot 4=0x5555) → rdata_a=rdata_b=0, rvalid=0; next read of slot 4 returns 0x5555. Reset asserted during a stall → all outputs 0 next cycle.

Source files
------------

// File: rtl/regfile_read_port.sv
// Decode-stage register file: one write port, two registered read ports, 1-cycle read latency.
// re=0 holds operands (refreshed by writes to the held slot); flush clears them; reset wins over all.
module regfile_read_port #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_write,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic              flush,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              rvalid
);

  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

  logic [WIDTH-1:0]  slots [NUM_REGS];
  logic [ADDR_W-1:0] held_a;
  logic [ADDR_W-1:0] held_b;

  logic              wr_ok;
  logic              byp_a;
  logic              byp_b;
  logic              rfr_a;
  logic              rfr_b;
  logic [WIDTH-1:0]  slot_a;
  logic [WIDTH-1:0]  slot_b;

  function automatic logic implemented(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < NUM_REGS_L;
  endfunction

  always_comb begin
    wr_ok  = en_write && implemented(waddr);
    byp_a  = wr_ok && (waddr == raddr_a);
    byp_b  = wr_ok && (waddr == raddr_b);
    // refresh keeps stalled operands coherent with writeback
    rfr_a  = wr_ok && (waddr == held_a);
    rfr_b  = wr_ok && (waddr == held_b);
    slot_a = '0;
    slot_b = '0;
    if (implemented(raddr_a)) slot_a = slots[raddr_a];
    if (implemented(raddr_b)) slot_b = slots[raddr_b];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) slots[i] <= '0;
    end else if (wr_ok) begin
      slots[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rdata_a <= '0;
      rdata_b <= '0;
      rvalid  <= 1'b0;
      held_a  <= '0;
      held_b  <= '0;
    end else if (re) begin
      rdata_a <= byp_a ? wdata : slot_a;
      rdata_b <= byp_b ? wdata : slot_b;
      rvalid  <= 1'b1;
      held_a  <= raddr_a;
      held_b  <= raddr_b;
    end else begin
      if (rfr_a) rdata_a <= wdata;
      if (rfr_b) rdata_b <= wdata;
    end
  end

endmodule
